cache_tag_lookup: RTL and testbench

//  Tag/valid store and hit detection placed directly upstream of replacement_policy.

---
 rtl/cache_tag_lookup.sv | 147 ++++++++++++++
 tb/tb_cache_tag_lookup.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_lookup.sv
// Set-associative tag/valid store with hit detection and miss/refill allocation.
// Optional INVALID_WAY_FIRST_EN: allocate the lowest invalid way before using way_select.
module cache_tag_lookup #(
  parameter int unsigned N_WAYS     = 4,
  parameter int unsigned LINE_OFF_W = 7,
  parameter int unsigned TAG_W      = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [TAG_W+LINE_OFF_W-1:0] req_addr,
  output logic                        req_ready,
  output logic                        rsp_valid,
  output logic                        rsp_hit,
  output logic                        miss,
  input  logic                        fill_valid,
  input  logic                        invalidate,
  input  logic [N_WAYS-1:0]           way_select,
  output logic [N_WAYS-1:0]           way_hit,
  output logic [LINE_OFF_W-1:0]       line_addr,
  output logic                        write_en
);

  localparam int unsigned Sets = 2 ** LINE_OFF_W;

  typedef enum logic [1:0] {StIdle, StLookup, StMiss, StDone} state_e;

  state_e                  state_q, state_d;
  logic [TAG_W-1:0]        tag_q;
  logic [LINE_OFF_W-1:0]   idx_q;
  logic [N_WAYS-1:0]       victim_q;
  logic [N_WAYS-1:0]       victim;
  logic [N_WAYS-1:0]       match;
  logic [N_WAYS-1:0]       cur_valid;
  logic [N_WAYS-1:0]       valid_q  [Sets];
  logic [TAG_W-1:0]        tag_mem  [N_WAYS][Sets];
  logic [TAG_W-1:0]        tag_rd_q [N_WAYS];
  logic                    accept;
  logic                    fill;

  assign accept    = reset && (state_q == StIdle) && req_valid && !invalidate;
  assign fill      = reset && (state_q == StMiss) && fill_valid;
  assign cur_valid = valid_q[idx_q];

  always_comb begin
    match = '0;
    for (int unsigned w = 0; w < N_WAYS; w++) begin
      match[w] = cur_valid[w] && (tag_rd_q[w] == tag_q);
    end
  end

`ifdef INVALID_WAY_FIRST_EN
  logic found;
  always_comb begin
    victim = way_select;
    found  = 1'b0;
    for (int unsigned w = 0; w < N_WAYS; w++) begin
      if (!found && !cur_valid[w]) begin
        victim    = '0;
        victim[w] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    victim = way_select;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLookup;
      StLookup: state_d = (|match) ? StIdle : StMiss;
      StMiss:   if (fill_valid) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      for (int unsigned s = 0; s < Sets; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && invalidate) begin
        for (int unsigned s = 0; s < Sets; s++) valid_q[s] <= '0;
      end else if (fill) begin
        valid_q[idx_q] <= valid_q[idx_q] | victim;
      end
    end
  end

  // Tag storage and the lookup latches are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q <= req_addr[TAG_W+LINE_OFF_W-1:LINE_OFF_W];
      idx_q <= req_addr[LINE_OFF_W-1:0];
    end
    if (fill) victim_q <= victim;
    for (int unsigned w = 0; w < N_WAYS; w++) begin
      if (fill && victim[w]) tag_mem[w][idx_q] <= tag_q;
      if (accept) tag_rd_q[w] <= tag_mem[w][req_addr[LINE_OFF_W-1:0]];
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    miss      = 1'b0;
    write_en  = 1'b0;
    way_hit   = '0;
    line_addr = '0;
    if (reset) begin
      unique case (state_q)
        StIdle: req_ready = !invalidate;
        StLookup: begin
          way_hit   = match;
          line_addr = idx_q;
          if (|match) begin
            rsp_valid = 1'b1;
            rsp_hit   = 1'b1;
            write_en  = 1'b1;
          end else begin
            miss = 1'b1;
          end
        end
        StMiss: line_addr = idx_q;
        StDone: begin
          rsp_valid = 1'b1;
          rsp_hit   = 1'b1;
          write_en  = 1'b1;
          way_hit   = victim_q;
          line_addr = idx_q;
        end
        default: ;
      endcase
    end
  end

  a_fill_onehot: assert property (@(posedge clk) fill |-> $onehot(way_select))
    else $error("way_select not one-hot during fill");

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Scoreboard bench for cache_tag_lookup: driver pushes expected events, monitor pops and compares.
module tb_cache_tag_lookup;
  localparam int NW = 4;
  localparam int LW = 7;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [TW+LW-1:0] req_addr;
  logic          req_ready, rsp_valid, rsp_hit, miss;
  logic          fill_valid, invalidate;
  logic [NW-1:0] way_select, way_hit;
  logic [LW-1:0] line_addr;
  logic          write_en;

  always #5 clk = ~clk;

  cache_tag_lookup #(.N_WAYS(NW), .LINE_OFF_W(LW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .miss(miss),
    .fill_valid(fill_valid), .invalidate(invalidate), .way_select(way_select),
    .way_hit(way_hit), .line_addr(line_addr), .write_en(write_en)
  );

  typedef struct {
    bit            is_miss;
    logic [NW-1:0] way;
    logic [LW-1:0] line;
    int            cyc;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  // Reference model: plain per-set tag/valid tables.
  logic [TW-1:0] mtag   [2**LW][NW];
  bit            mvalid [2**LW][NW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NW-1:0] pick_victim(input int s, input logic [NW-1:0] ws);
`ifdef INVALID_WAY_FIRST_EN
    for (int w = 0; w < NW; w++) if (!mvalid[s][w]) return NW'(1) << w;
`endif
    return ws;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2**LW; s++) for (int w = 0; w < NW; w++) mvalid[s][w] = 0;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
    end
  endtask

  // fill_dly < 0 leaves a miss unfilled.
  task automatic do_req(input logic [TW-1:0] tag, input logic [LW-1:0] idx,
                        input logic [NW-1:0] ws, input int fill_dly, output int acc);
    bit ok;
    logic [NW-1:0] hw, vic;
    ev_t e;
    acc = -1;
    wait_ready(ok);
    if (!ok) return;
    hw = '0;
    for (int w = 0; w < NW; w++) if (mvalid[idx][w] && mtag[idx][w] == tag) hw[w] = 1'b1;
    req_valid = 1'b1;
    req_addr  = {tag, idx};
    acc       = cyc + 1;
    e.is_miss = (hw == '0);
    e.way     = hw;
    e.line    = idx;
    e.cyc     = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = TW'($urandom);
    if (hw == '0 && fill_dly >= 0) begin
      repeat (1 + fill_dly) @(negedge clk);
      vic        = pick_victim(int'(idx), ws);
      way_select = ws;
      fill_valid = 1'b1;
      e.is_miss  = 0;
      e.way      = vic;
      e.line     = idx;
      e.cyc      = cyc + 1;
      sbq.push_back(e);
      for (int w = 0; w < NW; w++) if (vic[w]) begin
        mtag[idx][w]   = tag;
        mvalid[idx][w] = 1;
      end
      @(negedge clk);
      fill_valid = 1'b0;
      way_select = NW'($urandom);
    end
  endtask

  task automatic do_invalidate();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    invalidate = 1'b1;
    req_valid  = 1'b1;
    req_addr   = (TW+LW)'($urandom);
    #1 chk("ready_during_invalidate", req_ready, 0);
    @(negedge clk);
    invalidate = 1'b0;
    req_valid  = 1'b0;
    model_clear();
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_outputs"}, {rsp_valid, rsp_hit, miss, write_en, way_hit, line_addr}, 0);
    chk({nm, "_ready"}, req_ready, 0);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid === 1'b1 || miss === 1'b1 || write_en === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: rsp_valid=%b miss=%b write_en=%b at cycle %0d, expected none",
                   rsp_valid, miss, write_en, cyc);
        end else begin
          e = sbq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("miss", miss, e.is_miss);
          chk("rsp_valid", rsp_valid, !e.is_miss);
          chk("rsp_hit", rsp_hit, !e.is_miss);
          chk("write_en", write_en, !e.is_miss);
          chk("way_hit", way_hit, e.is_miss ? '0 : e.way);
          chk("line_addr", line_addr, e.line);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int accs[4];
    logic [TW-1:0] pool[6];
    logic [LW-1:0] idxs[4];
    pool[0] = 20'h00000; pool[1] = 20'hFFFFF; pool[2] = 20'h12345;
    pool[3] = 20'h00001; pool[4] = 20'hABCDE; pool[5] = 20'h54321;
    idxs[0] = 7'd0; idxs[1] = 7'd3; idxs[2] = 7'd4; idxs[3] = 7'd127;
    model_clear();
    reset = 1'b0; req_valid = 1'b0; req_addr = '0;
    fill_valid = 1'b0; invalidate = 1'b0; way_select = '0;
    repeat (3) begin
      @(negedge clk);
      #1 chk_quiet("reset");
    end
    reset = 1'b1;

    // Miss then allocate, then the same line hits.
    do_req(20'h12345, 7'd3, 4'b0100, 2, acc);
    do_req(20'h12345, 7'd3, 4'b0001, 0, acc);

    // Fill remaining ways of set 3, re-hit each, same tag at set 4 misses.
    do_req(20'h00001, 7'd3, 4'b0001, 0, acc);
    do_req(20'h00002, 7'd3, 4'b0010, 1, acc);
    do_req(20'h00003, 7'd3, 4'b1000, 3, acc);
    do_req(20'h00001, 7'd3, 4'b0001, 0, acc);
    do_req(20'h00002, 7'd3, 4'b0001, 0, acc);
    do_req(20'h00003, 7'd3, 4'b0001, 0, acc);
    do_req(20'h12345, 7'd3, 4'b0001, 0, acc);
    do_req(20'h12345, 7'd4, 4'b0001, 0, acc);

    // Invalidate wins over a simultaneous request.
    do_invalidate();
    do_req(20'h00001, 7'd3, 4'b0010, 0, acc);

    // Reset while waiting for a refill.
    do_req(20'h77777, 7'd5, 4'b0001, -1, acc);
    @(negedge clk);
    reset = 1'b0; fill_valid = 1'b1; way_select = 4'b0001;
    #1 chk_quiet("reset_in_miss");
    @(negedge clk);
    #1 chk_quiet("reset_in_miss_hold");
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    fill_valid = 1'b0;
    #1 chk("ready_after_reset", req_ready, 1);
    do_req(20'h12345, 7'd3, 4'b0100, 0, acc);

    // Back-to-back hits.
    do_req(20'hABCDE, 7'd0, 4'b1000, 0, acc);
    do_req(20'hFFFFF, 7'd127, 4'b0010, 0, acc);
    do_req(20'h12345, 7'd3, 4'b0001, 0, accs[0]);
    do_req(20'hABCDE, 7'd0, 4'b0001, 0, accs[1]);
    do_req(20'hFFFFF, 7'd127, 4'b0001, 0, accs[2]);
    do_req(20'h12345, 7'd3, 4'b0001, 0, accs[3]);
    for (int i = 1; i < 4; i++) chk("b2b_accept_spacing", accs[i] - accs[i-1], 2);

    // Randomized traffic over a small tag pool and boundary sets.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) do_invalidate();
      else do_req(pool[$urandom_range(0, 5)], idxs[$urandom_range(0, 3)],
                  4'b0001 << $urandom_range(0, 3), int'($urandom_range(0, 3)), acc);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
